// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer and future microstep blocks.
// No logic, no latency.
// No flow control; constants and a pure index helper only.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Coil pattern {A,B,C,D} per phase index; entry 0 is the rightmost element.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  // Advance the phase index by one step: stride 2 for full step, 1 for half step.
  // The 3-bit result wraps modulo 8 naturally.
  function automatic logic [2:0] next_phase_idx(input logic [2:0] idx,
                                                input logic       dir,
                                                input logic       half);
    logic [2:0] stride;
    stride = half ? 3'd1 : 3'd2;
    return (dir == DIR_REV) ? (idx - stride) : (idx + stride);
  endfunction

endpackage

// File: rtl/stepper_phase_lut.sv
// Combinational phase index -> coil pattern lookup.
// Zero latency (pure combinational).
// No flow control.
module stepper_phase_lut
  import stepper_pkg::*;
(
  input  logic [2:0] idx,
  output logic [3:0] coil
);

  assign coil = PHASE_TABLE[idx];

endmodule

// File: rtl/stepper_sequencer.sv
// Command-driven stepper sequencer pacing each step through an external delay_counter.
// Coil/position update on the edge ending STEP, two cycles after dly_done is seen in WAIT.
// cmd_ready only in IDLE; commands while busy are dropped. STEPPER_HALF_STEP_EN adds cmd_half.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int         POS_W       = 16,
  parameter int         STEPS_W     = 16,
  parameter logic [2:0] RESET_PHASE = 3'd1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic [7:0]         cmd_delay,
`ifdef STEPPER_HALF_STEP_EN
  input  logic               cmd_half,
`endif
  input  logic               abort,
  output logic               dly_start,
  output logic               dly_enable,
  output logic [7:0]         dly_delay,
  input  logic               dly_done,
  output logic [3:0]         coil,
  output logic [POS_W-1:0]   position,
  output logic               busy,
  output logic               move_done
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               step_en;
  logic               finish;
  logic               dir_q;
  logic               half_q;
  logic               zero_pend;
  logic [STEPS_W-1:0] remaining;
  logic [2:0]         phase_idx;
  logic [2:0]         idx_nxt;
  logic [3:0]         coil_nxt;

  assign idx_nxt = next_phase_idx(phase_idx, dir_q, half_q);

  stepper_phase_lut u_phase_lut (
    .idx  (idx_nxt),
    .coil (coil_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and decoded outputs; abort wins over a STEP update.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    dly_start  = 1'b0;
    dly_enable = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_steps != '0) begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        dly_start = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        dly_enable = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else if (dly_done) begin
          state_nxt = STEP;
        end
      end
      STEP: begin
        if (abort) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else begin
          step_en = 1'b1;
          if (remaining == STEPS_W'(1)) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latch; a zero-step command completes one cycle later via zero_pend.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_q     <= DIR_FWD;
      dly_delay <= 8'd0;
      zero_pend <= 1'b0;
      move_done <= 1'b0;
    end else begin
      zero_pend <= accept && (cmd_steps == '0);
      move_done <= finish || zero_pend;
      if (accept) begin
        dir_q     <= cmd_dir;
        dly_delay <= cmd_delay;
      end
    end
  end

`ifdef STEPPER_HALF_STEP_EN
  // Half-step mode is chosen per command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_q <= 1'b0;
    end else if (accept) begin
      half_q <= cmd_half;
    end
  end
`else
  assign half_q = 1'b0;
`endif

  // Step datapath: phase index, registered coil, wrapping position, remaining count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_idx <= RESET_PHASE;
      coil      <= PHASE_TABLE[RESET_PHASE];
      position  <= '0;
      remaining <= '0;
    end else if (accept) begin
      remaining <= cmd_steps;
    end else if (step_en) begin
      phase_idx <= idx_nxt;
      coil      <= coil_nxt;
      remaining <= remaining - STEPS_W'(1);
      if (dir_q == DIR_FWD) begin
        position <= position + POS_W'(1);
      end else begin
        position <= position - POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Randomized scoreboard bench for stepper_sequencer with a behavioural delay_counter.
// Expected coil steps and completions are queued at command issue; a negedge monitor checks them.
// Reset, directed moves, abort, zero-step, ignored commands, mid-move reset, optional half step.
module tb_stepper_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = 16'd0;
  logic [7:0]  cmd_delay = 8'd0;
`ifdef STEPPER_HALF_STEP_EN
  logic        cmd_half = 1'b0;
`endif
  logic        abort = 1'b0;
  logic        dly_start;
  logic        dly_enable;
  logic [7:0]  dly_delay;
  logic        dly_done;
  logic [3:0]  coil;
  logic [15:0] position;
  logic        busy;
  logic        move_done;

  stepper_sequencer #(
    .POS_W       (16),
    .STEPS_W     (16),
    .RESET_PHASE (3'd1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_delay  (cmd_delay),
`ifdef STEPPER_HALF_STEP_EN
    .cmd_half   (cmd_half),
`endif
    .abort      (abort),
    .dly_start  (dly_start),
    .dly_enable (dly_enable),
    .dly_delay  (dly_delay),
    .dly_done   (dly_done),
    .coil       (coil),
    .position   (position),
    .busy       (busy),
    .move_done  (move_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural delay_counter, BASIC_PERIOD=1: start clears, enable counts up to delay.
  logic [7:0] dc_cnt = 8'd0;
  logic       dc_done = 1'b0;
  assign dly_done = dc_done;
  always @(posedge clk) begin
    if (!reset_n) begin
      dc_cnt  <= 8'd0;
      dc_done <= 1'b0;
    end else if (dly_start) begin
      dc_cnt  <= 8'd0;
      dc_done <= 1'b0;
    end else if (dly_enable && !dc_done) begin
      dc_cnt <= dc_cnt + 8'd1;
      if ({1'b0, dc_cnt} + 9'd1 >= {1'b0, dly_delay}) dc_done <= 1'b1;
    end
  end

  // Reference model state and scoreboard queues.
  typedef struct {
    logic [3:0]  coil;
    logic [15:0] pos;
  } step_t;
  typedef struct {
    logic [15:0] pos;
    logic [3:0]  coil;
    int          starts;
    bit          zero;
  } done_t;

  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int          m_idx = 1;
  logic [15:0] m_pos = 16'd0;
  step_t       coil_q[$];
  done_t       done_q[$];
  logic [7:0]  exp_delay = 8'd0;
  int          zero_cyc = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every coil change and every move_done against the queues.
  initial begin
    logic [3:0] prev_coil;
    bit         prev_done;
    bit         dd_seen;
    int         dd_cyc;
    int         starts_seen;
    step_t      s;
    done_t      d;
    prev_coil = 4'b0; prev_done = 0; dd_seen = 0; dd_cyc = 0; starts_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_coil   = coil;
        prev_done   = 0;
        dd_seen     = 0;
        starts_seen = 0;
      end else begin
        if (dly_start) begin
          starts_seen++;
          dd_seen = 0;
          check("dly_delay_at_start", {24'd0, dly_delay}, {24'd0, exp_delay});
        end
        if (dly_enable && dly_done && !dd_seen) begin
          dd_seen = 1;
          dd_cyc  = cyc;
        end
        if (coil !== prev_coil) begin
          if (coil_q.size() == 0) begin
            fail_now("coil_unexpected_change");
          end else begin
            s = coil_q.pop_front();
            check("step_coil", {28'd0, coil}, {28'd0, s.coil});
            check("step_position", {16'd0, position}, {16'd0, s.pos});
            check("step_latency", cyc, dd_cyc + 2);
          end
          prev_coil = coil;
        end
        if (move_done) begin
          check("done_single_pulse", {31'd0, prev_done}, 32'd0);
          if (done_q.size() == 0) begin
            fail_now("move_done_unexpected");
          end else begin
            d = done_q.pop_front();
            check("done_position", {16'd0, position}, {16'd0, d.pos});
            check("done_coil", {28'd0, coil}, {28'd0, d.coil});
            check("done_start_count", starts_seen, d.starts);
            check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd0);
            check("done_dly_enable", {31'd0, dly_enable}, 32'd0);
            if (d.zero) check("zero_done_timing", cyc, zero_cyc + 1);
          end
          starts_seen = 0;
        end
        prev_done = move_done;
      end
    end
  end

  // Apply reset for one edge, check every output, then release.
  task automatic do_reset();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    check("rst_coil", {28'd0, coil}, 32'hC);
    check("rst_position", {16'd0, position}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dly_start", {31'd0, dly_start}, 32'd0);
    check("rst_dly_enable", {31'd0, dly_enable}, 32'd0);
    check("rst_dly_delay", {24'd0, dly_delay}, 32'd0);
    check("rst_move_done", {31'd0, move_done}, 32'd0);
    coil_q.delete();
    done_q.delete();
    m_idx     = 1;
    m_pos     = 16'd0;
    exp_delay = 8'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Queue the expected outcome of a move and hand the command over.
  task automatic send_cmd(input bit dir, input int steps, input int delay, input bit half,
                          input int abort_k, input bit abort_pin);
    int eff;
    int stride;
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("timeout_wait_idle");
    eff    = (abort_k >= 0) ? abort_k : steps;
    stride = half ? 1 : 2;
    for (int i = 0; i < eff; i++) begin
      m_idx = dir ? (m_idx + stride) % 8 : (m_idx + 8 - stride) % 8;
      m_pos = dir ? m_pos + 16'd1 : m_pos - 16'd1;
      coil_q.push_back('{tbl[m_idx], m_pos});
    end
    done_q.push_back('{m_pos, tbl[m_idx], (abort_k >= 0) ? abort_k + 1 : steps, steps == 0});
    exp_delay = delay[7:0];
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps[15:0];
    cmd_delay = delay[7:0];
`ifdef STEPPER_HALF_STEP_EN
    cmd_half  = half;
`endif
    abort     = abort_pin;
    @(posedge clk); #1;
    zero_cyc  = cyc;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // Run a move to completion, optionally aborting in WAIT after abort_k steps,
  // and poke ignored commands in while busy.
  task automatic run_move(input bit dir, input int steps, input int delay, input bit half,
                          input int abort_k, input bit abort_pin);
    int  starts;
    bit  aborted;
    bit  ok;
    starts = 0; aborted = 0; ok = 0;
    send_cmd(dir, steps, delay, half, abort_k, abort_pin);
    for (int c = 0; c < 2000; c++) begin
      if (done_q.size() == 0 && cmd_ready) begin ok = 1; break; end
      if (busy) check("busy_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      if (dly_start) starts++;
      if (abort_k >= 0 && !aborted && starts == abort_k + 1 && dly_enable) begin
        abort   = 1'b1;
        aborted = 1;
      end else if (dly_enable && $urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd_dir   = $urandom_range(0, 1) == 1;
        cmd_steps = 16'($urandom_range(0, 9));
        cmd_delay = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
    end
    if (!ok) fail_now("timeout_move_complete");
  endtask

  initial begin
    int st;
    bit ok;
    bit rdir;
    bit rhalf;
    int rsteps;
    int rdelay;
    int rk;
    bit rpin;

    do_reset();
    run_move(1'b1, 4, 2, 1'b0, -1, 1'b0);      // fwd 4: 0110 0011 1001 1100, pos 4
    do_reset();
    run_move(1'b0, 3, 1, 1'b0, -1, 1'b0);      // rev 3 from 0: pos 0xFFFD
    do_reset();
    run_move(1'b1, 5, 2, 1'b0, 1, 1'b0);       // abort in WAIT of step 2: pos 1, coil 0110
    run_move(1'b1, 0, 3, 1'b0, -1, 1'b0);      // zero-step: no start, no coil change
    run_move(1'b1, 3, 0, 1'b0, -1, 1'b1);      // abort alongside a command in IDLE: accepted
`ifdef STEPPER_HALF_STEP_EN
    do_reset();
    run_move(1'b1, 2, 1, 1'b1, -1, 1'b0);      // half step: 0100 0110, pos 2
`endif

    // Reset in the middle of a move.
    send_cmd(1'b1, 6, 3, 1'b0, -1, 1'b0);
    st = 0; ok = 0;
    for (int c = 0; c < 300; c++) begin
      if (dly_start) st++;
      if (st >= 3) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("timeout_mid_move");
    do_reset();

    for (int i = 0; i < 25; i++) begin
      rdir   = $urandom_range(0, 1) == 1;
`ifdef STEPPER_HALF_STEP_EN
      rhalf  = $urandom_range(0, 1) == 1;
`else
      rhalf  = 1'b0;
`endif
      rsteps = $urandom_range(0, 6);
      rdelay = $urandom_range(0, 3);
      rk     = -1;
      rpin   = 1'b0;
      if (rsteps > 0 && $urandom_range(0, 3) == 0) rk = $urandom_range(0, rsteps - 1);
      else if ($urandom_range(0, 4) == 0) rpin = 1'b1;
      run_move(rdir, rsteps, rdelay, rhalf, rk, rpin);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queues_drained", coil_q.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_sequencer.md
Name: stepper_sequencer

Overview:
Command-driven stepper motor sequencer that sits directly upstream of delay_counter. It accepts a move command (direction, step count, inter-step delay) and drives the coil phase pattern. It uses delay_counter to pace each step, issuing start/enable/delay and consuming done. It tracks a wrapping absolute position and signals move completion to the host/control logic.

Parameters:
POS_W, 16, width of absolute position register (two's complement, wraps)
STEPS_W, 16, width of commanded step count
RESET_PHASE, 3'd1, phase-table index loaded at reset (1 -> coil 4'b1100)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
cmd_valid  in  1  move command present
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready at posedge
cmd_dir  in  1  1 = forward (+1/step), 0 = reverse (-1/step)
cmd_steps  in  STEPS_W  number of steps to execute
cmd_delay  in  8  inter-step delay passed to delay_counter
abort  in  1  terminate move in progress
dly_start  out  1  to delay_counter start
dly_enable  out  1  to delay_counter enable
dly_delay  out  8  to delay_counter delay (latched cmd_delay)
dly_done  in  1  from delay_counter done
coil  out  4  coil drive pattern {A,B,C,D}
position  out  POS_W  absolute step position
busy  out  1  high in any state except IDLE
move_done  out  1  one-cycle pulse on normal or aborted completion

Behaviour:
- Reset values: state IDLE, phase index RESET_PHASE, coil 4'b1100, position 0, remaining 0, dly_delay 0, dly_start 0, dly_enable 0, move_done 0, busy 0. Reset overrides all inputs, including mid-move.
- Phase table index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. coil = table[idx], registered.
- Full-step mode: idx += 2 (fwd) / -= 2 (rev), modulo 8. Starting from odd idx gives two-phase-on drive.
- State machine states: IDLE, LOAD, WAIT, STEP.
  - IDLE: cmd_ready=1. On accept, latch dir, steps, delay. If cmd_steps==0, stay in IDLE and pulse move_done next cycle with no coil change. Otherwise go to LOAD.
  - LOAD: dly_start=1 for exactly one cycle, dly_enable=0. Next state WAIT.
  - WAIT: dly_enable=1. dly_done is only sampled here; it is cleared by the start pulse in LOAD. On dly_done=1 go to STEP.
  - STEP: single cycle. Update idx and coil; position ±1 with two's-complement wrap (0x7FFF+1 -> 0x8000, 0 -1 -> 0xFFFF); remaining -= 1. If the new remaining is 0, go to IDLE and pulse move_done. Else go to LOAD.
- Latency: the coil changes on the posedge at the end of STEP, i.e. 2 cycles after dly_done is first seen high in WAIT (WAIT->STEP, STEP->update).
- Abort: in LOAD, WAIT or STEP, the next state is IDLE and move_done pulses. Abort has priority over a STEP update in the same cycle, so no coil/position change occurs. Coil holds its last pattern. dly_enable drops. Abort in IDLE is ignored.
- cmd_valid while busy: ignored, no queuing.
- A cmd_valid and abort arriving together in IDLE: the command is accepted.

Optional Feature:
- Macro: STEPPER_HALF_STEP_EN.
- Defined: adds input port cmd_half (1 bit), latched on accept. When the latched value is 1, idx steps ±1 (8-state half-step) and position still changes ±1 per step. When 0, the block behaves exactly as full-step.
- Not defined: no cmd_half port; full-step only (idx ±2).

Decomposition:
- Shared package stepper_pkg holds:
  - state enum {IDLE, LOAD, WAIT, STEP}
  - phase-table constant (8x4)
  - DIR_FWD/DIR_REV constants
- One natural sub-module: stepper_phase_lut, a combinational idx -> coil lookup, reused by future microstep blocks.
- delay_counter is instantiated alongside this block at top level, not inside it.

Test Plan:
- Bench setup for all scenarios: delay_counter with BASIC_PERIOD=1, clk 10 ns.
- Reset then idle: coil=1100, position=0, cmd_ready=1, busy=0.
- Forward move, cmd_steps=4, cmd_dir=1, cmd_delay=2: exactly 4 dly_start pulses; coil sequence 0110, 0011, 1001, 1100; position=4; one move_done pulse; back in IDLE.
- Reverse move from position 0, 3 steps: coil 1001, 0011, 0110; position=0xFFFD.
- Abort asserted mid-WAIT of step 2 of 5: position=1, coil frozen at 0110, move_done pulses once, dly_enable=0 the next cycle, then cmd_ready=1.
- cmd_steps=0: no dly_start pulse, coil unchanged, move_done 2 cycles after accept. Also check that cmd_valid during busy is ignored.
- With STEPPER_HALF_STEP_EN defined, cmd_half=1, 2 fwd steps from reset: coil 0100, 0110; position=2. Also assert reset_n low mid-move and check all outputs return to reset values on the next edge.
